vga_fb_80x60: RTL
=================

Name: vga_fb_80x60

Overview:
- Framebuffer stage directly upstream of the 80x60 VGA driver.
- Holds an 80x60 grid of 8-bit RGB332 pixels. Each pixel is displayed as an 8x8 block of 640x480 screen pixels.
- Serves the driver's ROW/COLUMN lookups combinationally, so colour is valid before the driver's clock edge.
- MCU side gets a single-cycle pixel write port, a 1-cycle-latency readback port and a hardware clear-screen engine.

Parameters:
- FB_COLS, 80, framebuffer columns.
- FB_ROWS, 60, framebuffer rows.
- SCALE_SHIFT, 3, log2 of screen pixels per framebuffer pixel in each axis.

Ports:
- CLK_25MHz  in  1  pixel clock; shared with the VGA driver.
- RST_N  in  1  synchronous, active-low reset.
- WA  in  13  MCU write address {row[5:0], col[6:0]}.
- WD  in  8  MCU write pixel, RGB332 as {R[2:0],G[2:0],B[1:0]}.
- WE  in  1  MCU write strobe.
- RA  in  13  MCU readback address, same format as WA.
- RD  out  8  MCU readback data.
- CLR  in  1  clear-screen request, single-cycle pulse.
- CLR_COLOR  in  8  fill colour, sampled when CLR is accepted.
- BUSY  out  1  clear engine active.
- ROW  in  10  driver vertical coordinate, 0..524.
- COLUMN  in  10  driver horizontal coordinate, 0..799.
- RED  out  3  pixel colour to driver.
- GREEN  out  3  pixel colour to driver.
- BLUE  out  2  pixel colour to driver.

Behaviour:
- Reset is sampled only on posedge CLK_25MHz with RST_N=0. It sets:
  - state = IDLE, BUSY=0, RD=8'h00;
  - clear counters = 0, latched fill colour = 8'h00.
- Memory contents are not reset.
- Memory: 8192x8, addressed {row[5:0], col[6:0]}. Only row<60 and col<80 are valid; other locations are never written.
- Display read path (combinational, zero latency):
  - addr = {ROW[8:3], COLUMN[9:3]}.
  - When ROW<480 and COLUMN<640: {RED,GREEN,BLUE} = mem[addr].
  - Otherwise {RED,GREEN,BLUE} = 0.
  - No registers in this path.
- MCU write: on a clock edge with WE=1 and WA in range (col<80, row<60), mem[WA] <= WD. Out-of-range writes are silently dropped.
- MCU readback: RD <= mem[RA] every cycle, so there is 1-cycle latency. Out-of-range RA returns 8'h00.
- A write and a readback to the same address in the same cycle: RD returns the old data (read-before-write).
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when CLR=1. Latch CLR_COLOR, set row_cnt=0, col_cnt=0. BUSY=1 from the next cycle.
  - CLEAR: each cycle without an MCU write, write the latched colour to {row_cnt,col_cnt}, then advance col_cnt. col_cnt wraps 79->0 and increments row_cnt.
  - CLEAR -> IDLE on the cycle that writes {59,79}. BUSY=0 on the following cycle.
  - An uninterrupted clear takes exactly 4800 write cycles.
- Arbitration: a valid MCU write has priority. In that cycle the clear engine stalls and its counters hold; BUSY stays 1.
- Pixels already cleared that are then written by the MCU keep the MCU value.
- CLR while BUSY=1 is ignored: no restart, and the colour is not re-latched.
- RST_N=0 mid-clear aborts the clear immediately. Partially cleared memory is retained.
- The display path keeps reading throughout a clear; tearing is acceptable.

Decomposition:
- Package vga_fb_pkg holds:
  - FB_COLS=80, FB_ROWS=60, FB_AW=13;
  - typedef fb_addr_t = struct packed {logic [5:0] row; logic [6:0] col};
  - typedef rgb332_t;
  - enum clr_state_t {IDLE, CLEAR}.
- Sub-module fb_ram_8k: 1 write port, 1 synchronous read port (MCU readback), 1 asynchronous read port (display). Infer as distributed RAM.
- The top module holds address mapping, range checks, clear FSM and arbitration.

Test Plan:
- Pixel write/display:
  - Stimulus: WE with WA={6'd2,7'd5}, WD=8'hE0; then sweep ROW 16..23, COLUMN 40..47.
  - Response: RED=3'b111, GREEN=0, BLUE=0 throughout. At ROW=16, COLUMN=48 the output is the adjacent pixel.
- Blanking:
  - Stimulus: fill mem with 8'hFF; drive ROW=100, COLUMN=640, then ROW=480, COLUMN=0.
  - Response: {RED,GREEN,BLUE}=0 in both cases.
- Readback:
  - Stimulus: write 8'h5A to {10,20}; set RA={10,20} on the next cycle.
  - Response: RD=8'h5A one cycle later. RA={0,80} -> RD=8'h00.
- Out-of-range write:
  - Stimulus: WE with WA={6'd60,7'd0} and {6'd0,7'd100}, WD=8'h33.
  - Response: memory unchanged; no aliasing into {0,0} or any row <60.
- Clear with interruption:
  - Stimulus: CLR with CLR_COLOR=8'h1C; 10 MCU writes during BUSY; CLR re-pulsed mid-clear.
  - Response: BUSY high for exactly 4810 cycles. All pixels = 8'h1C except the MCU-written pixels written after being cleared.
- Reset mid-clear:
  - Stimulus: RST_N=0 for one cycle at clear cycle 1000.
  - Response: BUSY=0 and RD=0 next cycle; pixels {0,0}..{12,39} = fill colour; the rest unchanged.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types and geometry for the 80x60 RGB332 framebuffer feeding the VGA driver.
package vga_fb_pkg;

    localparam int FB_COLS     = 80;
    localparam int FB_ROWS     = 60;
    localparam int FB_AW       = 13;
    localparam int SCALE_SHIFT = 3;
    localparam int SCR_W       = FB_COLS << SCALE_SHIFT;
    localparam int SCR_H       = FB_ROWS << SCALE_SHIFT;

    typedef struct packed {
        logic [5:0] row;
        logic [6:0] col;
    } fb_addr_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    function automatic logic addr_valid(input fb_addr_t a);
        return (a.row < 6'(FB_ROWS)) && (a.col < 7'(FB_COLS));
    endfunction

endpackage

// File: rtl/vga_fb_80x60_if.sv
// MCU write/readback/clear signals plus the VGA driver lookup, bundled for the framebuffer.
interface vga_fb_80x60_if;
    import vga_fb_pkg::*;

    fb_addr_t   WA;
    logic [7:0] WD;
    logic       WE;
    fb_addr_t   RA;
    logic [7:0] RD;
    logic       CLR;
    logic [7:0] CLR_COLOR;
    logic       BUSY;
    logic [9:0] ROW;
    logic [9:0] COLUMN;
    logic [2:0] RED;
    logic [2:0] GREEN;
    logic [1:0] BLUE;

    modport slave (
        input  WA, WD, WE, RA, CLR, CLR_COLOR, ROW, COLUMN,
        output RD, BUSY, RED, GREEN, BLUE
    );

    modport master (
        output WA, WD, WE, RA, CLR, CLR_COLOR, ROW, COLUMN,
        input  RD, BUSY, RED, GREEN, BLUE
    );

endinterface

// File: rtl/fb_ram_8k.sv
// 8192x8 distributed RAM: one write port, a registered MCU read port and an
// asynchronous display read port.
module fb_ram_8k
    import vga_fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [FB_AW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic             ren_i,
    input  logic [FB_AW-1:0] raddr_i,
    output logic [7:0]       rdata_o,
    input  logic [FB_AW-1:0] daddr_i,
    output logic [7:0]       ddata_o
);

    logic [7:0] mem_q [0:(1 << FB_AW) - 1];
    logic [7:0] rdata_q;

    // NOTE: the array has no reset; a reset would forbid distributed-RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: non-blocking updates mean this read sees the pre-write contents (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (ren_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;
    assign ddata_o = mem_q[daddr_i];

endmodule

// File: rtl/vga_fb_80x60.sv
// 80x60 RGB332 framebuffer: zero-latency display lookup, MCU write/readback and
// a clear-screen engine that yields to MCU writes.
module vga_fb_80x60
    import vga_fb_pkg::*;
(
    input  logic           CLK_25MHz,
    input  logic           RST_N,
    vga_fb_80x60_if.slave  bus
);

    clr_state_t state_q, state_d;
    logic [5:0] row_cnt_q, row_cnt_d;
    logic [6:0] col_cnt_q, col_cnt_d;
    logic [7:0] fill_q, fill_d;

    logic       mcu_wr_ok;
    logic       rd_ok;
    logic       clr_we;
    logic       ram_we;
    fb_addr_t   clr_addr;
    fb_addr_t   ram_waddr;
    logic [7:0] ram_wdata;
    fb_addr_t   disp_addr;
    logic [7:0] disp_px;
    logic       on_screen;
    rgb332_t    disp_rgb;

    assign mcu_wr_ok = bus.WE && addr_valid(bus.WA);
    assign rd_ok     = addr_valid(bus.RA);

    always_ff @(posedge CLK_25MHz) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            fill_q    <= fill_d;
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        fill_d    = fill_q;
        clr_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.CLR) begin
                    state_d   = CLEAR;
                    fill_d    = bus.CLR_COLOR;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            CLEAR: begin
                // An MCU write owns the port this cycle; the sweep simply holds.
                if (!mcu_wr_ok) begin
                    clr_we = 1'b1;
                    if (col_cnt_q == 7'(FB_COLS - 1)) begin
                        col_cnt_d = '0;
                        if (row_cnt_q == 6'(FB_ROWS - 1)) begin
                            state_d   = IDLE;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + 6'd1;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset kills the pending clear write on the very edge it is sampled.
    assign clr_addr  = {row_cnt_q, col_cnt_q};
    assign ram_we    = mcu_wr_ok || (clr_we && RST_N);
    assign ram_waddr = mcu_wr_ok ? bus.WA : clr_addr;
    assign ram_wdata = mcu_wr_ok ? bus.WD : fill_q;

    assign on_screen = (bus.ROW < 10'(SCR_H)) && (bus.COLUMN < 10'(SCR_W));
    assign disp_addr = {bus.ROW[SCALE_SHIFT +: 6], bus.COLUMN[SCALE_SHIFT +: 7]};
    assign disp_rgb  = on_screen ? rgb332_t'(disp_px) : '0;

    fb_ram_8k u_ram (
        .clk     (CLK_25MHz),
        .rst_n   (RST_N),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .ren_i   (rd_ok),
        .raddr_i (bus.RA),
        .rdata_o (bus.RD),
        .daddr_i (disp_addr),
        .ddata_o (disp_px)
    );

    assign bus.BUSY  = (state_q == CLEAR);
    assign bus.RED   = disp_rgb.r;
    assign bus.GREEN = disp_rgb.g;
    assign bus.BLUE  = disp_rgb.b;

endmodule
